host_bus_target: RTL and testbench
==================================

# host_bus_target

Parametrised host-bus target that terminates the active-low `wr_n`/`rd_n` host bus into a local register bank. It generalises the fixed 16-bit host port to configurable address width, data width, register count and base address. It adds a `ready_n` wait-state handshake, read-data output enable, per-register write pulses and access-error reporting. It sits between the host bus pins (tri-state split into `data_in`/`data_out`/`data_oe` at the top level) and the DUT-side configuration logic.

## Interface
- `ADDR_W`, 16: address bus width.
- `DATA_W`, 16: data bus width.
- `NUM_REGS`, 8: register count, range 1..256.
- `BASE_ADDR`, 16'h0000: address of register 0. Register i is at `BASE_ADDR+i`.
- `WAIT_CYCLES`, 2: wait states inserted before the access completes, range 0..15.
- `RESET_VAL`, 0: reset value of every register, DATA_W wide.

- `clk`, in, 1: single clock; all state on posedge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `wr_n`, in, 1: host write strobe, active-low, synchronous to `clk`.
- `rd_n`, in, 1: host read strobe, active-low, synchronous to `clk`.
- `address`, in, ADDR_W: host address.
- `data_in`, in, DATA_W: host write data.
- `data_out`, out, DATA_W: read data toward the host.
- `data_oe`, out, 1: drive-enable for `data_out` onto the shared bus.
- `ready_n`, out, 1: access complete, active-low.
- `regs_flat`, out, NUM_REGS*DATA_W: register bank contents. Register i is at bits `[i*DATA_W +: DATA_W]`.
- `wr_pulse`, out, NUM_REGS: one-cycle pulse on the register just written.
- `err`, out, 1: one-cycle pulse on an access error.

## Operation
- **Reset values:**
  - `data_out`=0, `data_oe`=0, `ready_n`=1, `wr_pulse`=0, `err`=0.
  - All registers = RESET_VAL.
  - FSM = IDLE; the strobe history registers `wr_q`/`rd_q` = 1.
- **Start condition:** in IDLE, an edge that samples a strobe at 0 with its `*_q` history at 1.
  - On that edge, latch `address`, the `data_in` value (writes only) and the direction.
  - The history registers update every cycle.
- **Both strobes low on the same start edge:** illegal. Pulse `err`, perform no access, go to HOLD.
- **FSM states:**
  - IDLE: on a start edge go to WAIT, or go directly to ACCESS when WAIT_CYCLES=0.
  - WAIT: counts WAIT_CYCLES edges, then goes to ACCESS.
    - If the active strobe is sampled high during WAIT, abort: pulse `err`, no register change, `ready_n` stays 1, go to IDLE.
  - ACCESS: one edge.
    - Write in range: update the register, pulse its `wr_pulse` bit, set `ready_n`=0.
    - Read: load `data_out` with the register value, or all-ones when out of range. Set `ready_n`=0.
    - Out of range (`address` < BASE_ADDR or ≥ BASE_ADDR+NUM_REGS): pulse `err`. A write is discarded.
    - Then go to HOLD.
  - HOLD: hold `ready_n`=0 (and `data_out`) until both strobes are sampled high. Then set `ready_n`=1, `data_oe`=0, go to IDLE.
- **Read output enable:** `data_oe` is 1 from the edge after the read start through the end of HOLD.
- **Address arithmetic:** offset = `address` − BASE_ADDR in ADDR_W+1 bits. This guarantees wrap-around never aliases a low address into range.
- **No pipelining:** strobe edges seen outside IDLE are ignored; one access is in flight at a time.
- **`rst_n` assertion:** mid-access or at any time, it immediately forces every reset value. No partial write occurs.

## Timing
- Edge 0 is the start edge.
- `ready_n` falls after edge WAIT_CYCLES+1.
- `regs_flat` and `wr_pulse` change after the same edge as `ready_n`.
- `data_out` is valid when `ready_n` is 0.
- `ready_n` rises one edge after both strobes are sampled high.
- Minimum access, strobe low to `ready_n` high: WAIT_CYCLES+3 cycles.
- `err` and `wr_pulse` last exactly one cycle.

## Test plan
- **Reset:** hold `rst_n`=0 → all outputs at reset values, `regs_flat` all RESET_VAL. Release → no `ready_n` activity until a strobe falls.
- **Write then read** (defaults): write 16'hA5C3 to address 16'h0003.
  - `ready_n` falls 3 cycles after the start edge.
  - `wr_pulse`=8'b0000_1000 for one cycle; `regs_flat[63:48]`=16'hA5C3.
  - Read back address 3 → `data_out`=16'hA5C3 with `data_oe`=1.
- **Out-of-range access:**
  - Write to 16'h0008 → `err` pulses, `ready_n` still completes, `regs_flat` unchanged.
  - Read from 16'h0008 → `data_out`=16'hFFFF.
- **Early strobe release:** release `wr_n` during WAIT (1 cycle after start) → `err` pulses, `ready_n` never falls, no register change.
- **Both strobes low:** drive `wr_n`=`rd_n`=0 on the same edge → `err` pulses, no access. The next access is accepted only after both strobes return high.
- **Parameter variant and mid-access reset:** with WAIT_CYCLES=0, ADDR_W=8, DATA_W=32, BASE_ADDR=8'hF0, NUM_REGS=16, write address 8'hFF → `ready_n` falls 1 cycle after start. Then assert `rst_n` during HOLD → all outputs and registers return to reset values at once.

Source files
------------

// File: rtl/host_bus_target.sv
// Host-bus target: terminates the active-low wr_n/rd_n host bus into a local
// register bank, with wait states, a ready_n handshake, read-data output
// enable, per-register write pulses and access-error reporting.
module host_bus_target #(
    parameter int unsigned       ADDR_W      = 16,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       NUM_REGS    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_n,
    input  logic                         rd_n,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_oe,
    output logic                         ready_n,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_pulse,
    output logic                         err
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_HOLD
    } state_t;

    state_t              state_q;
    logic                wr_q;
    logic                rd_q;
    logic                is_rd_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          cnt_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   data_out_q;
    logic                data_oe_q;
    logic                ready_n_q;
    logic                err_q;
    logic [NUM_REGS-1:0] wr_pulse_q;

    logic [ADDR_W:0]     offset_d;
    logic                in_range_d;
    logic [IDX_W-1:0]    idx_d;
    logic                wr_start_d;
    logic                rd_start_d;
    logic                active_n_d;

    // Address decode and strobe-edge detection; the offset carries one extra
    // bit so addresses below BASE_ADDR land far out of range instead of wrapping.
    always_comb begin
        offset_d   = {1'b0, addr_q} - {1'b0, BASE_ADDR};
        in_range_d = offset_d < (ADDR_W+1)'(NUM_REGS);
        idx_d      = offset_d[IDX_W-1:0];
        wr_start_d = !wr_n && wr_q;
        rd_start_d = !rd_n && rd_q;
        active_n_d = is_rd_q ? rd_n : wr_n;
    end

    // Access FSM, register bank and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_q       <= 1'b1;
            rd_q       <= 1'b1;
            is_rd_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            data_oe_q  <= 1'b0;
            ready_n_q  <= 1'b1;
            err_q      <= 1'b0;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            wr_q       <= wr_n;
            rd_q       <= rd_n;
            err_q      <= 1'b0;
            wr_pulse_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (wr_start_d || rd_start_d) begin
                        if (!wr_n && !rd_n) begin
                            err_q   <= 1'b1;
                            state_q <= S_HOLD;
                        end else begin
                            addr_q    <= address;
                            is_rd_q   <= !rd_n;
                            data_oe_q <= !rd_n;
                            cnt_q     <= '0;
                            if (!wr_n) begin
                                wdata_q <= data_in;
                            end
                            state_q <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (active_n_d) begin
                        err_q     <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == 4'(WAIT_CYCLES - 1)) begin
                        state_q <= S_ACCESS;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                S_ACCESS: begin
                    ready_n_q <= 1'b0;
                    if (is_rd_q) begin
                        data_out_q <= in_range_d ? regs_q[idx_d] : '1;
                    end else if (in_range_d) begin
                        regs_q[idx_d]     <= wdata_q;
                        wr_pulse_q[idx_d] <= 1'b1;
                    end
                    if (!in_range_d) begin
                        err_q <= 1'b1;
                    end
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (wr_n && rd_n) begin
                        ready_n_q <= 1'b1;
                        data_oe_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Flatten the register bank for the configuration side.
    always_comb begin
        regs_flat = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;
    assign ready_n  = ready_n_q;
    assign wr_pulse = wr_pulse_q;
    assign err      = err_q;

endmodule

// File: tb/tb_host_bus_target.sv
// Bench for host_bus_target: default instance checked every cycle against a
// transaction-level expectation model, plus a directed parameter variant.
module tb_host_bus_target;

    localparam int          TW    = 2;
    localparam int          TNR   = 8;
    localparam logic [15:0] TBASE = 16'h0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic         rst_n, wr_n, rd_n;
    logic [15:0]  address, data_in, data_out;
    logic         data_oe, ready_n, err;
    logic [127:0] regs_flat;
    logic [7:0]   wr_pulse;

    // variant instance
    logic         rst1_n, wr1_n, rd1_n;
    logic [7:0]   addr1;
    logic [31:0]  din1, dout1;
    logic         oe1, rdy1, err1;
    logic [511:0] regs1;
    logic [15:0]  wrp1;

    host_bus_target dut (
        .clk(clk), .rst_n(rst_n), .wr_n(wr_n), .rd_n(rd_n),
        .address(address), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .ready_n(ready_n), .regs_flat(regs_flat),
        .wr_pulse(wr_pulse), .err(err)
    );

    host_bus_target #(
        .ADDR_W(8), .DATA_W(32), .NUM_REGS(16), .BASE_ADDR(8'hF0),
        .WAIT_CYCLES(0), .RESET_VAL(32'h0)
    ) dut1 (
        .clk(clk), .rst_n(rst1_n), .wr_n(wr1_n), .rd_n(rd1_n),
        .address(addr1), .data_in(din1), .data_out(dout1),
        .data_oe(oe1), .ready_n(rdy1), .regs_flat(regs1),
        .wr_pulse(wrp1), .err(err1)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // expectation model state
    logic        e_ready, e_err, e_oe, e_oe_chk, e_dout_chk;
    logic [7:0]  e_wrp;
    logic [15:0] e_dout;
    logic [15:0] m_regs [TNR];
    logic [127:0] ef;

    // monitor state (written only by the compare process)
    int   edge_no = 0;
    int   n_fall = 0, fall_edge = 0, n_err = 0, n_wrp = 0;
    logic prev_rdy = 1'b1;
    logic [7:0]  wrp_last = '0;
    logic [15:0] dout_last = '0;

    always @(posedge clk) edge_no++;

    // Compare the default instance against the model on every cycle.
    always @(negedge clk) begin
        for (int i = 0; i < TNR; i++) ef[i*16 +: 16] = m_regs[i];
        chk("ready_n", 128'(ready_n), 128'(e_ready));
        chk("err", 128'(err), 128'(e_err));
        chk("wr_pulse", 128'(wr_pulse), 128'(e_wrp));
        chk("regs_flat", regs_flat, ef);
        if (e_oe_chk) chk("data_oe", 128'(data_oe), 128'(e_oe));
        if (e_dout_chk) chk("data_out", 128'(data_out), 128'(e_dout));
        if (prev_rdy === 1'b1 && ready_n === 1'b0) begin
            n_fall++;
            fall_edge = edge_no;
        end
        prev_rdy = ready_n;
        if (err === 1'b1) n_err++;
        if (wr_pulse != 8'h00) begin
            wrp_last = wr_pulse;
            n_wrp++;
        end
        if (ready_n === 1'b0 && data_oe === 1'b1) dout_last = data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        e_err = 1'b0;
        e_wrp = '0;
    endtask

    // One host access; abort_at=k releases the strobe before wait edge k.
    task automatic access(input bit rd, input logic [15:0] a, input logic [15:0] d,
                          input int hold, input int abort_at, output int se);
        int off;
        bit inr;
        bit aborted;
        off = int'(a) - int'(TBASE);
        inr = (off >= 0) && (off < TNR);
        aborted = 1'b0;
        address = a;
        data_in = d;
        if (rd) rd_n = 1'b0; else wr_n = 1'b0;
        tick();
        se = edge_no;
        address = 16'($urandom);
        data_in = 16'($urandom);
        if (rd) e_oe_chk = 1'b0;
        for (int k = 1; k <= TW; k++) begin
            if (!aborted) begin
                if (abort_at == k) begin
                    wr_n = 1'b1;
                    rd_n = 1'b1;
                end
                tick();
                if (abort_at == k) begin
                    e_err = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        if (aborted) begin
            tick();
            e_oe = 1'b0;
            e_oe_chk = 1'b1;
            return;
        end
        tick();
        e_ready = 1'b0;
        if (rd) begin
            e_dout = inr ? m_regs[off] : 16'hFFFF;
            e_dout_chk = 1'b1;
            e_oe = 1'b1;
            e_oe_chk = 1'b1;
        end else if (inr) begin
            m_regs[off] = d;
            e_wrp[off] = 1'b1;
        end
        if (!inr) e_err = 1'b1;
        repeat (hold) tick();
        wr_n = 1'b1;
        rd_n = 1'b1;
        tick();
        e_ready = 1'b1;
        e_oe = 1'b0;
        e_oe_chk = 1'b1;
        e_dout_chk = 1'b0;
    endtask

    // Both strobes fall together; a later wr_n fall while rd_n is still low must be ignored.
    task automatic both_low();
        address = 16'($urandom);
        data_in = 16'($urandom);
        wr_n = 1'b0;
        rd_n = 1'b0;
        tick();
        e_err = 1'b1;
        tick();
        wr_n = 1'b1;
        tick();
        tick();
        wr_n = 1'b0;
        tick();
        tick();
        wr_n = 1'b1;
        rd_n = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int se, e0, f0, w0;
        rst_n = 1'b0; wr_n = 1'b1; rd_n = 1'b1; address = '0; data_in = '0;
        rst1_n = 1'b0; wr1_n = 1'b1; rd1_n = 1'b1; addr1 = '0; din1 = '0;
        e_ready = 1'b1; e_err = 1'b0; e_wrp = '0; e_oe = 1'b0; e_oe_chk = 1'b1;
        e_dout = '0; e_dout_chk = 1'b1;
        for (int i = 0; i < TNR; i++) m_regs[i] = '0;

        // reset held
        repeat (3) tick();
        chk("rst_ready_n", 128'(ready_n), 128'(1'b1));
        chk("rst_regs", regs_flat, 128'h0);
        rst_n = 1'b1;
        e_dout_chk = 1'b0;
        repeat (4) tick();
        chk("idle_no_ready", 128'(n_fall), 128'(0));

        // write A5C3 to register 3
        w0 = n_wrp;
        access(1'b0, 16'h0003, 16'hA5C3, 0, 0, se);
        chk("wr_latency", 128'(fall_edge - se), 128'(3));
        chk("wr_pulse_val", 128'(wrp_last), 128'(8'b0000_1000));
        chk("wr_pulse_len", 128'(n_wrp - w0), 128'(1));
        chk("reg3_val", 128'(regs_flat[63:48]), 128'(16'hA5C3));

        // read it back
        access(1'b1, 16'h0003, 16'h0000, 1, 0, se);
        chk("rd_latency", 128'(fall_edge - se), 128'(3));
        chk("rd_data", 128'(dout_last), 128'(16'hA5C3));

        // out-of-range write and read
        e0 = n_err; f0 = n_fall;
        access(1'b0, 16'h0008, 16'h1234, 0, 0, se);
        chk("oor_wr_err", 128'(n_err - e0), 128'(1));
        chk("oor_wr_ready", 128'(n_fall - f0), 128'(1));
        chk("oor_wr_regs", regs_flat, 128'h0000_0000_0000_0000_A5C3_0000_0000_0000);
        e0 = n_err;
        access(1'b1, 16'h0008, 16'h0000, 0, 0, se);
        chk("oor_rd_err", 128'(n_err - e0), 128'(1));
        chk("oor_rd_data", 128'(dout_last), 128'(16'hFFFF));

        // early strobe release one cycle after start
        e0 = n_err; f0 = n_fall;
        access(1'b0, 16'h0005, 16'h7777, 0, 1, se);
        chk("abort_err", 128'(n_err - e0), 128'(1));
        chk("abort_no_ready", 128'(n_fall - f0), 128'(0));
        chk("abort_reg5", 128'(regs_flat[95:80]), 128'(16'h0000));

        // both strobes low together, then a normal access is accepted
        e0 = n_err; f0 = n_fall;
        both_low();
        chk("both_err", 128'(n_err - e0), 128'(1));
        chk("both_no_ready", 128'(n_fall - f0), 128'(0));
        access(1'b0, 16'h0001, 16'h0F0F, 0, 0, se);
        chk("after_both_ready", 128'(n_fall - f0), 128'(1));
        chk("after_both_reg1", 128'(regs_flat[31:16]), 128'(16'h0F0F));

        // randomized traffic against the model
        for (int t = 0; t < 60; t++) begin
            int r;
            logic [15:0] a;
            repeat ($urandom % 3) tick();
            r = $urandom % 10;
            if (r == 0) begin
                both_low();
            end else begin
                if ($urandom % 4 == 0) a = 16'($urandom);
                else a = 16'($urandom % 10);
                access(1'($urandom % 2), a, 16'($urandom), int'($urandom % 3),
                       ($urandom % 6 == 0) ? int'(1 + $urandom % TW) : 0, se);
            end
        end
        repeat (2) tick();

        // variant: WAIT_CYCLES=0, 8-bit address, 32-bit data, base F0, 16 regs
        chk("v_rst_ready_n", 128'(rdy1), 128'(1'b1));
        chk("v_rst_oe", 128'(oe1), 128'(1'b0));
        rst1_n = 1'b1;
        tick();
        addr1 = 8'hFF;
        din1 = 32'hDEAD_BEEF;
        wr1_n = 1'b0;
        tick();
        chk("v_e0_ready_n", 128'(rdy1), 128'(1'b1));
        tick();
        chk("v_ready_fall", 128'(rdy1), 128'(1'b0));
        chk("v_wr_pulse", 128'(wrp1), 128'(16'h8000));
        chk("v_reg15", 128'(regs1[511:480]), 128'(32'hDEAD_BEEF));
        chk("v_err", 128'(err1), 128'(1'b0));
        tick();
        chk("v_hold_ready_n", 128'(rdy1), 128'(1'b0));
        chk("v_pulse_len", 128'(wrp1), 128'(16'h0000));
        #2;
        rst1_n = 1'b0;
        #1;
        chk("v_midrst_ready_n", 128'(rdy1), 128'(1'b1));
        chk("v_midrst_regs", 128'(regs1 == '0), 128'(1'b1));
        chk("v_midrst_dout", 128'(dout1), 128'(32'h0));
        chk("v_midrst_oe", 128'(oe1), 128'(1'b0));
        chk("v_midrst_err", 128'(err1), 128'(1'b0));
        wr1_n = 1'b1;
        tick();
        rst1_n = 1'b1;
        tick();
        // address 00 sits below the base and must not alias into range
        addr1 = 8'h00;
        din1 = 32'h1111_2222;
        wr1_n = 1'b0;
        tick();
        tick();
        chk("v_low_err", 128'(err1), 128'(1'b1));
        chk("v_low_ready_n", 128'(rdy1), 128'(1'b0));
        chk("v_low_pulse", 128'(wrp1), 128'(16'h0000));
        chk("v_low_regs", 128'(regs1 == '0), 128'(1'b1));
        wr1_n = 1'b1;
        tick();
        chk("v_low_release", 128'(rdy1), 128'(1'b1));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
